// File: rtl/gpio_arb.sv
// rtl/gpio_arb.sv - two-requester GPIO access arbiter, optional round robin via GPIO_ARB_RR_EN
module gpio_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [1:0]       m0_a,
  input  logic [1:0]       m1_a,
  input  logic [WIDTH-1:0] m0_wd,
  input  logic [WIDTH-1:0] m1_wd,
  output logic             m0_ack,
  output logic             m1_ack,
  output logic [WIDTH-1:0] rd_o,
  output logic             gp_we,
  output logic [1:0]       gp_a,
  output logic [WIDTH-1:0] gp_wd,
  input  logic [WIDTH-1:0] gp_rd,
  output logic             busy,
  output logic             gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       a_q, a_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             id_q, id_d;
  logic             any_req;
  logic             win;

  assign any_req = m0_req | m1_req;

`ifdef GPIO_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Winner selection: ptr names the favoured requester on a tie; it flips away from each grantee
  always_comb begin
    ptr_d = ptr_q;
    if (m0_req && m1_req) begin
      win = ptr_q;
    end else begin
      win = ~m0_req;
    end
    if (state_q == S_IDLE && any_req) begin
      ptr_d = ~win;
    end
  end

  // Round-robin pointer register; reset favours m0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: m0 wins whenever it is requesting
  always_comb win = ~m0_req;
`endif

  // Next-state and latch logic for the IDLE -> ACC -> RESP sequence
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACC;
          id_d    = win;
          we_d    = win ? m1_we : m0_we;
          a_d     = win ? m1_a  : m0_a;
          wd_d    = win ? m1_wd : m0_wd;
        end
      end
      S_ACC: begin
        state_d = S_RESP;
        if (!we_q) begin
          rd_d = gp_rd;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers; async reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      a_q     <= 2'd0;
      wd_q    <= '0;
      rd_q    <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      id_q    <= id_d;
    end
  end

  // gp_we decodes straight from state so a reset drops it without waiting for clk
  assign gp_we  = (state_q == S_ACC) & we_q;
  assign gp_a   = a_q;
  assign gp_wd  = wd_q;
  assign rd_o   = rd_q;
  assign m0_ack = (state_q == S_RESP) & ~id_q;
  assign m1_ack = (state_q == S_RESP) & id_q;
  assign busy   = (state_q != S_IDLE);
  assign gnt_id = id_q;

endmodule

// File: tb/tb_gpio_arb.sv
// tb/tb_gpio_arb.sv - randomized and directed bench for gpio_arb
module tb_gpio_arb;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [1:0]   m0_a = 2'd0, m1_a = 2'd0;
  logic [W-1:0] m0_wd = '0, m1_wd = '0;
  logic         m0_ack, m1_ack, gp_we, busy, gnt_id;
  logic [W-1:0] rd_o, gp_wd, gp_rd;
  logic [1:0]   gp_a;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpio_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_a(m0_a), .m1_a(m1_a), .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .rd_o(rd_o),
    .gp_we(gp_we), .gp_a(gp_a), .gp_wd(gp_wd), .gp_rd(gp_rd),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Stand-in GPIO register file, with an override used to present a fixed read value
  logic [W-1:0] dev_mem [4];
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dev_mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (gp_we) begin
      dev_mem[gp_a] <= gp_wd;
    end
  end
  assign gp_rd = force_en ? force_val : dev_mem[gp_a];

  // Transaction-level reference: a grant at edge c owns the bus until edge c+3
  int           cyc = 0;
  int           t_grant = -10;
  int           next_free = 0;
  logic         last_w, exp_gnt, lat_we;
  logic [1:0]   lat_a;
  logic [W-1:0] lat_wd, exp_rd;
  logic [W-1:0] ref_regs [4];

  task automatic model_reset();
    t_grant = -10;
    next_free = cyc;
    last_w = 1'b1;
    exp_gnt = 1'b0;
    lat_we = 1'b0;
    lat_a = 2'd0;
    lat_wd = '0;
    exp_rd = '0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 32'hC0DE_0000 + 32'(i);
  endtask

  task automatic model_edge();
    logic w;
    if (cyc == t_grant + 1) begin
      if (lat_we) ref_regs[lat_a] = lat_wd;
      else exp_rd = ref_regs[lat_a];
    end
    if (cyc >= next_free && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
`ifdef GPIO_ARB_RR_EN
        w = ~last_w;
`else
        w = 1'b0;
`endif
      end else begin
        w = m1_req;
      end
      last_w = w;
      exp_gnt = w;
      t_grant = cyc;
      next_free = cyc + 3;
      lat_we = w ? m1_we : m0_we;
      lat_a = w ? m1_a : m0_a;
      lat_wd = w ? m1_wd : m0_wd;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    force_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total += 8;
    if (gp_we !== 1'b0)  begin bad++; $display("FAIL rst_gp_we got %b want 0", gp_we); end
    if (gp_a !== 2'd0)   begin bad++; $display("FAIL rst_gp_a got %h want 0", gp_a); end
    if (gp_wd !== '0)    begin bad++; $display("FAIL rst_gp_wd got %h want 0", gp_wd); end
    if (rd_o !== '0)     begin bad++; $display("FAIL rst_rd_o got %h want 0", rd_o); end
    if (m0_ack !== 1'b0) begin bad++; $display("FAIL rst_m0_ack got %b want 0", m0_ack); end
    if (m1_ack !== 1'b0) begin bad++; $display("FAIL rst_m1_ack got %b want 0", m1_ack); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    if (gnt_id !== 1'b0) begin bad++; $display("FAIL rst_gnt_id got %b want 0", gnt_id); end
    rst_n = 1'b1;
  endtask

  task automatic test_m0_write();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'd2; m0_wd = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    total += 6;
    if (gp_we !== 1'b1)         begin bad++; $display("FAIL wr_acc_gp_we got %b want 1", gp_we); end
    if (gp_a !== 2'd2)          begin bad++; $display("FAIL wr_acc_gp_a got %h want 2", gp_a); end
    if (gp_wd !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_acc_gp_wd got %h want a5a50001", gp_wd); end
    if (busy !== 1'b1)          begin bad++; $display("FAIL wr_acc_busy got %b want 1", busy); end
    if (gnt_id !== 1'b0)        begin bad++; $display("FAIL wr_acc_gnt got %b want 0", gnt_id); end
    if (m0_ack !== 1'b0)        begin bad++; $display("FAIL wr_acc_ack got %b want 0", m0_ack); end
    @(negedge clk);
    total += 4;
    if (gp_we !== 1'b0)  begin bad++; $display("FAIL wr_resp_gp_we got %b want 0", gp_we); end
    if (m0_ack !== 1'b1) begin bad++; $display("FAIL wr_resp_m0_ack got %b want 1", m0_ack); end
    if (m1_ack !== 1'b0) begin bad++; $display("FAIL wr_resp_m1_ack got %b want 0", m1_ack); end
    if (rd_o !== '0)     begin bad++; $display("FAIL wr_resp_rd_o got %h want 0", rd_o); end
    m0_req = 1'b0;
    @(negedge clk);
    total += 2;
    if (m0_ack !== 1'b0) begin bad++; $display("FAIL wr_idle_ack got %b want 0", m0_ack); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL wr_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_m1_read();
    force_en = 1'b1; force_val = 32'h1234_5678;
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'd0; m1_wd = $urandom;
    @(posedge clk);
    @(negedge clk);
    total += 3;
    if (gp_we !== 1'b0)  begin bad++; $display("FAIL rd_acc_gp_we got %b want 0", gp_we); end
    if (gp_a !== 2'd0)   begin bad++; $display("FAIL rd_acc_gp_a got %h want 0", gp_a); end
    if (gnt_id !== 1'b1) begin bad++; $display("FAIL rd_acc_gnt got %b want 1", gnt_id); end
    @(negedge clk);
    total += 4;
    if (m1_ack !== 1'b1)        begin bad++; $display("FAIL rd_resp_m1_ack got %b want 1", m1_ack); end
    if (m0_ack !== 1'b0)        begin bad++; $display("FAIL rd_resp_m0_ack got %b want 0", m0_ack); end
    if (rd_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp_rd_o got %h want 12345678", rd_o); end
    if (gp_we !== 1'b0)         begin bad++; $display("FAIL rd_resp_gp_we got %b want 0", gp_we); end
    m1_req = 1'b0;
    force_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total += 1;
    if (rd_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_hold_rd_o got %h want 12345678", rd_o); end
  endtask

  task automatic test_back_to_back();
    int n_ack, last_ack_cyc;
    logic want;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_a = 2'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'd3;
    n_ack = 0;
    last_ack_cyc = -1;
    for (int k = 0; k < 40 && n_ack < 4; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
`ifdef GPIO_ARB_RR_EN
        want = n_ack[0];
`else
        want = 1'b0;
`endif
        total += 2;
        if ({m1_ack, m0_ack} !== (want ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL b2b_grant%0d got m1_ack=%b m0_ack=%b want owner m%0d", n_ack, m1_ack, m0_ack, want);
        end
        if (last_ack_cyc >= 0 && k - last_ack_cyc != 3) begin
          bad++; $display("FAIL b2b_spacing%0d got %0d want 3", n_ack, k - last_ack_cyc);
        end
        last_ack_cyc = k;
        n_ack++;
      end
    end
    total += 1;
    if (n_ack != 4) begin bad++; $display("FAIL b2b_count got %0d want 4", n_ack); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pulse();
    int n0, n1, nwe, first_ack;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'd1; m0_wd = 32'h5A5A_F00D;
    @(posedge clk);
    @(negedge clk);
    m0_req = 1'b0;
    nwe = gp_we ? 1 : 0;
    n0 = 0; n1 = 0; first_ack = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m0_ack) begin n0++; if (first_ack < 0) first_ack = k; end
      if (m1_ack) n1++;
      if (gp_we) nwe++;
    end
    total += 4;
    if (n0 != 1)        begin bad++; $display("FAIL pulse_m0_acks got %0d want 1", n0); end
    if (n1 != 0)        begin bad++; $display("FAIL pulse_m1_acks got %0d want 0", n1); end
    if (nwe != 1)       begin bad++; $display("FAIL pulse_gp_we_cycles got %0d want 1", nwe); end
    if (first_ack != 0) begin bad++; $display("FAIL pulse_ack_cycle got %0d want 0", first_ack); end
  endtask

  task automatic test_reset_abort();
    int nack;
    logic got;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'd3; m0_wd = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    total += 1;
    if (gp_we !== 1'b1) begin bad++; $display("FAIL abort_pre_gp_we got %b want 1", gp_we); end
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (gp_we !== 1'b0)  begin bad++; $display("FAIL abort_gp_we got %b want 0", gp_we); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    if (m0_ack !== 1'b0) begin bad++; $display("FAIL abort_ack got %b want 0", m0_ack); end
    m0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) nack++;
    end
    total += 1;
    if (nack != 0) begin bad++; $display("FAIL abort_late_ack got %0d want 0", nack); end
    m0_req = 1'b1; m0_we = 1'b0; m0_a = 2'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'd1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        got = 1'b1;
        total += 1;
        if ({m1_ack, m0_ack} !== 2'b01) begin
          bad++; $display("FAIL abort_first_tie got m1_ack=%b m0_ack=%b want m0", m1_ack, m0_ack);
        end
      end
    end
    total += 1;
    if (!got) begin bad++; $display("FAIL abort_tie_timeout got no ack want ack within 10 cycles"); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(int n);
    logic p0, p1, in_acc, in_resp;
    int e;
    do_reset();
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
        m0_a = 2'($urandom_range(0, 3)); m0_wd = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
        m1_a = 2'($urandom_range(0, 3)); m1_wd = $urandom;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      e = cyc - 1;
      in_acc = (e == t_grant);
      in_resp = (e == t_grant + 1);
      total += 8;
      if (gp_we !== (in_acc && lat_we))        begin bad++; $display("FAIL rnd_gp_we cyc %0d got %b want %b", e, gp_we, in_acc && lat_we); end
      if (busy !== (in_acc || in_resp))        begin bad++; $display("FAIL rnd_busy cyc %0d got %b want %b", e, busy, in_acc || in_resp); end
      if (m0_ack !== (in_resp && !exp_gnt))    begin bad++; $display("FAIL rnd_m0_ack cyc %0d got %b want %b", e, m0_ack, in_resp && !exp_gnt); end
      if (m1_ack !== (in_resp && exp_gnt))     begin bad++; $display("FAIL rnd_m1_ack cyc %0d got %b want %b", e, m1_ack, in_resp && exp_gnt); end
      if (rd_o !== exp_rd)                     begin bad++; $display("FAIL rnd_rd_o cyc %0d got %h want %h", e, rd_o, exp_rd); end
      if (gnt_id !== exp_gnt)                  begin bad++; $display("FAIL rnd_gnt_id cyc %0d got %b want %b", e, gnt_id, exp_gnt); end
      if (gp_a !== lat_a)                      begin bad++; $display("FAIL rnd_gp_a cyc %0d got %h want %h", e, gp_a, lat_a); end
      if (gp_wd !== lat_wd)                    begin bad++; $display("FAIL rnd_gp_wd cyc %0d got %h want %h", e, gp_wd, lat_wd); end
      if (in_resp) begin
        if (!exp_gnt) begin p0 = 1'b0; m0_req = 1'b0; end
        else begin p1 = 1'b0; m1_req = 1'b0; end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_back_to_back();
    test_pulse();
    test_reset_abort();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
